stream_top_k: RTL and testbench

Tracks the K largest samples seen on a data stream since the last clear. Keeps them as a sorted, registered list, each entry with its arrival index. Replaces the earlier two-entry largest-value tracker in the stream-statistics path. Adds configurable depth, width and signedness, per-slot valid flags so zero and negative samples are ranked correctly, and arrival-index capture.

---
 rtl/stream_top_k.sv | 106 ++++++++++
 tb/tb_stream_top_k.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/stream_top_k.sv
// Running top-K tracker: keeps the K largest samples since the last clear as a
// sorted, registered list (slot 0 = largest), each tagged with its arrival index.
module stream_top_k #(
  parameter int WIDTH  = 32,
  parameter int K      = 4,
  parameter int SIGNED = 0,
  parameter int IDX_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_vld,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_clr,
  output logic [K*WIDTH-1:0]         out_data,
  output logic [K*IDX_W-1:0]         out_idx,
  output logic [K-1:0]               out_valid,
  output logic [$clog2(K+1)-1:0]     out_count
);

  localparam int CW = $clog2(K+1);

  // Handshake: a sample is taken on every rising edge where in_vld=1 and
  // in_clr=0; there is no ready, so the source never stalls.

  logic [WIDTH-1:0] data_q  [K];
  logic [IDX_W-1:0] idx_q   [K];
  logic [K-1:0]     valid_q;
  logic [IDX_W-1:0] cnt_q;
  logic [CW-1:0]    count_q;

  logic [K-1:0]     win;
  logic [K-1:0]     take_new;
  logic [K-1:0]     take_prev;
  logic [WIDTH-1:0] prev_data [K];
  logic [IDX_W-1:0] prev_idx  [K];
  logic [K-1:0]     prev_valid;
  logic             accept;

  assign accept = in_vld & ~in_clr;

  function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  // Because the list is sorted and valid slots are contiguous, win[] is a
  // thermometer: the insertion point is simply the lowest winning slot.
  for (genvar g = 0; g < K; g++) begin : g_slot
    assign win[g] = !valid_q[g] || gt(in_data, data_q[g]);

    if (g == 0) begin : g_head
      assign take_new[g]   = win[g];
      assign take_prev[g]  = 1'b0;
      assign prev_data[g]  = '0;
      assign prev_idx[g]   = '0;
      assign prev_valid[g] = 1'b0;
    end else begin : g_body
      assign take_new[g]   = win[g] & ~win[g-1];
      assign take_prev[g]  = win[g] &  win[g-1];
      assign prev_data[g]  = data_q[g-1];
      assign prev_idx[g]   = idx_q[g-1];
      assign prev_valid[g] = valid_q[g-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q[g]  <= '0;
        idx_q[g]   <= '0;
        valid_q[g] <= 1'b0;
      end else if (in_clr) begin
        data_q[g]  <= '0;
        idx_q[g]   <= '0;
        valid_q[g] <= 1'b0;
      end else if (accept && take_new[g]) begin
        data_q[g]  <= in_data;
        idx_q[g]   <= cnt_q;
        valid_q[g] <= 1'b1;
      end else if (accept && take_prev[g]) begin
        data_q[g]  <= prev_data[g];
        idx_q[g]   <= prev_idx[g];
        valid_q[g] <= prev_valid[g];
      end
    end

    assign out_data[g*WIDTH +: WIDTH] = data_q[g];
    assign out_idx[g*IDX_W +: IDX_W]  = idx_q[g];
  end

  // Any insertion makes the last slot win; count grows only while not full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      count_q <= '0;
    end else if (in_clr) begin
      cnt_q   <= '0;
      count_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + IDX_W'(1);
      if (win[K-1] && !valid_q[K-1]) count_q <= count_q + CW'(1);
    end
  end

  assign out_valid = valid_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_stream_top_k.sv
// Directed bench for stream_top_k: unsigned, signed and narrow-index instances
// share one stimulus stream; each check is an immediate assertion.
module tb_stream_top_k;

  logic        clk;
  logic        rst_n;
  logic        in_vld;
  logic [31:0] in_data;
  logic        in_clr;

  logic [127:0] out_data_u, out_data_s, out_data_w;
  logic [63:0]  out_idx_u, out_idx_s;
  logic [15:0]  out_idx_w;
  logic [3:0]   out_valid_u, out_valid_s, out_valid_w;
  logic [2:0]   out_count_u, out_count_s, out_count_w;

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q[$];

  stream_top_k #(.WIDTH(32), .K(4), .SIGNED(0), .IDX_W(16)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_data(in_data), .in_clr(in_clr),
    .out_data(out_data_u), .out_idx(out_idx_u), .out_valid(out_valid_u), .out_count(out_count_u)
  );

  stream_top_k #(.WIDTH(32), .K(4), .SIGNED(1), .IDX_W(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_data(in_data), .in_clr(in_clr),
    .out_data(out_data_s), .out_idx(out_idx_s), .out_valid(out_valid_s), .out_count(out_count_s)
  );

  stream_top_k #(.WIDTH(32), .K(4), .SIGNED(0), .IDX_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_data(in_data), .in_clr(in_clr),
    .out_data(out_data_w), .out_idx(out_idx_w), .out_valid(out_valid_w), .out_count(out_count_w)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks: inputs change on the falling edge, outputs are sampled there too
  task automatic send(input logic [31:0] d);
    in_vld  = 1'b1;
    in_data = d;
    @(negedge clk);
    in_vld  = 1'b0;
    in_data = '0;
  endtask

  task automatic clear(input logic with_vld);
    in_clr  = 1'b1;
    in_vld  = with_vld;
    in_data = 32'd100;
    @(negedge clk);
    in_clr  = 1'b0;
    in_vld  = 1'b0;
    in_data = '0;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    in_vld  = 1'b0;
    in_data = '0;
    in_clr  = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_data",  out_data_u,  128'd0);
    chk("rst_idx",   out_idx_u,   128'd0);
    chk("rst_valid", out_valid_u, 128'd0);
    chk("rst_count", out_count_u, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic ranking with a tie: 5,9,3,9,7
    send(32'd5); send(32'd9); send(32'd3); send(32'd9); send(32'd7);
    chk("basic_data",  out_data_u,  {32'd5, 32'd7, 32'd9, 32'd9});
    chk("basic_idx",   out_idx_u,   {16'd0, 16'd4, 16'd3, 16'd1});
    chk("basic_valid", out_valid_u, 128'hF);
    chk("basic_count", out_count_u, 128'd4);

    // signed vs unsigned ordering
    clear(1'b0);
    send(32'hFFFF_FFFF); send(32'h0000_0000); send(32'h8000_0000);
    chk("sgn_data",  out_data_s,  {32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0});
    chk("sgn_idx",   out_idx_s,   {16'd0, 16'd2, 16'd0, 16'd1});
    chk("sgn_valid", out_valid_s, 128'h7);
    chk("sgn_count", out_count_s, 128'd3);
    chk("uns_data",  out_data_u,  {32'h0, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF});
    chk("uns_idx",   out_idx_u,   {16'd0, 16'd1, 16'd2, 16'd0});
    chk("uns_valid", out_valid_u, 128'h7);

    // zero samples are real entries
    clear(1'b0);
    send(32'd0); send(32'd0);
    chk("zero_valid", out_valid_u, 128'h3);
    chk("zero_idx",   out_idx_u,   {16'd0, 16'd0, 16'd1, 16'd0});
    chk("zero_count", out_count_u, 128'd2);

    // full list: tie with last slot dropped, larger sample evicts it
    clear(1'b0);
    send(32'd9); send(32'd8); send(32'd7); send(32'd6);
    chk("full_count", out_count_u, 128'd4);
    send(32'd6);
    chk("full_tie_data", out_data_u, {32'd6, 32'd7, 32'd8, 32'd9});
    chk("full_tie_idx",  out_idx_u,  {16'd3, 16'd2, 16'd1, 16'd0});
    send(32'd7);
    chk("full_ins_data", out_data_u, {32'd7, 32'd7, 32'd8, 32'd9});
    chk("full_ins_idx",  out_idx_u,  {16'd5, 16'd2, 16'd1, 16'd0});

    // clear wins over a same-cycle sample
    clear(1'b1);
    chk("clr_valid", out_valid_u, 128'd0);
    chk("clr_count", out_count_u, 128'd0);
    chk("clr_data",  out_data_u,  128'd0);
    send(32'd1);
    chk("post_clr_data",  out_data_u,  {32'd0, 32'd0, 32'd0, 32'd1});
    chk("post_clr_idx",   out_idx_u,   128'd0);
    chk("post_clr_valid", out_valid_u, 128'h1);

    // narrow index counter wraps past 15
    clear(1'b0);
    for (int i = 1; i <= 20; i++) send(32'(i));
    exp_q.push_back({96'd0, 4'd0, 4'd1, 4'd2, 4'd3});
    exp_q.push_back({32'd17, 32'd18, 32'd19, 32'd20});
    exp_q.push_back(128'hF);
    chk("wrap_idx",   out_idx_w,   exp_q.pop_front());
    chk("wrap_data",  out_data_w,  exp_q.pop_front());
    chk("wrap_valid", out_valid_w, exp_q.pop_front());

    // asynchronous reset between clock edges
    send(32'd50); send(32'd60);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_data",  out_data_u,  128'd0);
    chk("arst_valid", out_valid_u, 128'd0);
    chk("arst_count", out_count_u, 128'd0);
    chk("arst_w_idx", out_idx_w,   128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'd4); send(32'd2);
    chk("resume_data",  out_data_u,  {32'd0, 32'd0, 32'd2, 32'd4});
    chk("resume_idx",   out_idx_u,   {16'd0, 16'd0, 16'd1, 16'd0});
    chk("resume_valid", out_valid_u, 128'h3);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
